rib_arbiter: RTL

Shared-bus interconnect between the `tiny_riscv` core and its memory/peripheral slaves. It arbitrates three masters by fixed priority, decodes the address onto one of four slaves, and runs a req/ack transaction with a timeout. It returns registered read data and drives the core's `rib_hold_flag_i` stall input. The core is master 2, with `mem_req_o`, `mem_we_o`, `mem_waddr_o`/`mem_raddr_o` muxed to one address, `mem_wdata_o` and `mem_rdata_i`. Masters 0 and 1 are debug agents (JTAG, UART loader).

---
 rtl/rib_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/rib_arbiter.sv
// Three-master, four-slave shared bus for tiny_riscv: fixed-priority grant,
// nibble address decode, req/ack handshake with timeout, and core stall output.
module rib_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic [31:0] m0_rdata_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic [31:0] m1_rdata_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    input  logic        m2_req_i,
    input  logic        m2_we_i,
    input  logic [31:0] m2_addr_i,
    input  logic [31:0] m2_wdata_i,
    output logic [31:0] m2_rdata_o,
    output logic        m2_ack_o,
    output logic        m2_err_o,

    output logic        s0_req_o,
    input  logic [31:0] s0_rdata_i,
    input  logic        s0_ack_i,
    output logic        s1_req_o,
    input  logic [31:0] s1_rdata_i,
    input  logic        s1_ack_i,
    output logic        s2_req_o,
    input  logic [31:0] s2_rdata_i,
    input  logic        s2_ack_i,
    output logic        s3_req_o,
    input  logic [31:0] s3_rdata_i,
    input  logic        s3_ack_i,

    output logic [31:0] s_addr_o,
    output logic        s_we_o,
    output logic [31:0] s_wdata_o,
    output logic        hold_flag_o
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    // Only addr[29:0] is kept: [31:30] are known zero once a slave is decoded.
    typedef struct packed {
        logic        we;
        logic [29:0] addr;
        logic [31:0] wdata;
    } req_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [2:0]        m_req;
    logic [2:0]        m_we;
    logic [2:0][31:0]  m_addr;
    logic [2:0][31:0]  m_wdata;
    logic [3:0]        s_ack;
    logic [3:0][31:0]  s_rdata;

    assign m_req   = {m2_req_i, m1_req_i, m0_req_i};
    assign m_we    = {m2_we_i, m1_we_i, m0_we_i};
    assign m_addr  = {m2_addr_i, m1_addr_i, m0_addr_i};
    assign m_wdata = {m2_wdata_i, m1_wdata_i, m0_wdata_i};
    assign s_ack   = {s3_ack_i, s2_ack_i, s1_ack_i, s0_ack_i};
    assign s_rdata = {s3_rdata_i, s2_rdata_i, s1_rdata_i, s0_rdata_i};

    state_t      state, state_d;
    logic [7:0]  cnt, cnt_d;
    req_t        req_q, req_d;
    logic [1:0]  grant, grant_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [1:0]  g;
    logic [1:0]  slave;

    assign slave = req_q.addr[29:28];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            req_q   <= '0;
            grant   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            req_q   <= req_d;
            grant   <= grant_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        req_d   = req_q;
        grant_d = grant;
        rdata_d = rdata_q;
        err_d   = err_q;
        g       = m_req[0] ? 2'd0 : (m_req[1] ? 2'd1 : 2'd2);
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (|m_req) begin
                    grant_d = g;
                    req_d   = '{we: m_we[g], addr: m_addr[g][29:0], wdata: m_wdata[g]};
                    if (m_addr[g][31:30] == 2'b00) begin
                        state_d = ACCESS;
                    end else begin
                        // Unmapped nibble: answer straight away with an error.
                        state_d = RESP;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (s_ack[slave]) begin
                    rdata_d = s_rdata[slave];
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic       in_access, in_resp;
    logic [3:0] s_sel;
    logic [2:0] m_ack;

    assign in_access = (state == ACCESS);
    assign in_resp   = (state == RESP);
    assign s_sel     = in_access ? (4'b0001 << slave) : 4'b0000;
    assign m_ack     = in_resp ? (3'b001 << grant) : 3'b000;

    assign {s3_req_o, s2_req_o, s1_req_o, s0_req_o} = s_sel;
    assign s_addr_o  = in_access ? {4'h0, req_q.addr[27:0]} : 32'h0;
    assign s_we_o    = in_access & req_q.we;
    assign s_wdata_o = in_access ? req_q.wdata : 32'h0;

    assign {m2_ack_o, m1_ack_o, m0_ack_o} = m_ack;
    assign {m2_err_o, m1_err_o, m0_err_o} = m_ack & {3{err_q}};
    assign m0_rdata_o = m_ack[0] ? rdata_q : 32'h0;
    assign m1_rdata_o = m_ack[1] ? rdata_q : 32'h0;
    assign m2_rdata_o = m_ack[2] ? rdata_q : 32'h0;

    // The core stalls until its own response cycle, or whenever debug owns the bus.
    assign hold_flag_o = m2_req_i ? !(in_resp && grant == 2'd2)
                                  : ((state != IDLE) || m0_req_i || m1_req_i);

endmodule
